// File: rtl/controle_multiciclo.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// with Moore strobes, Mealy-qualified memory handshakes and a bounded wait counter.
module controle_multiciclo #(
  parameter int unsigned WAIT_LIMIT = 15,
  parameter int unsigned WAIT_W     = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_timeout
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADDR  = 4'd3,
    S_MEMREAD  = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWRITE = 4'd6,
    S_REXEC    = 4'd7,
    S_RWB      = 4'd8,
    S_IEXEC    = 4'd9,
    S_IWB      = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [WAIT_W-1:0] LIMIT    = WAIT_LIMIT[WAIT_W-1:0];
  localparam logic              LIMIT_ON = (WAIT_LIMIT != 0);

  state_t            curState;
  state_t            nextState;
  logic [WAIT_W-1:0] waitCnt;
  logic [WAIT_W-1:0] waitCntNext;
  logic              memState;
  logic              timeout;
  logic              stall;

  assign memState = (curState == S_FETCH) || (curState == S_MEMREAD) ||
                    (curState == S_MEMWRITE);
  assign timeout  = memState && !mem_ready && LIMIT_ON && (waitCnt == LIMIT);
  assign stall    = memState && !mem_ready && !timeout;

  // Counter only survives while stalling in place, so every entry starts at zero.
  always_comb begin
    waitCntNext = '0;
    if (stall)
      waitCntNext = (waitCnt == '1) ? waitCnt : waitCnt + WAIT_W'(1);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      curState <= S_RESET;
      waitCnt  <= '0;
    end else begin
      curState <= nextState;
      waitCnt  <= waitCntNext;
    end
  end

  always_comb begin
    nextState   = S_FETCH;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_timeout = 1'b0;

    // A timed-out memory state drops all of its strobes and restarts at fetch.
    if (timeout) begin
      mem_timeout = 1'b1;
      nextState   = S_FETCH;
    end else begin
      unique case (curState)
        S_RESET: nextState = S_FETCH;
        S_FETCH: begin
          MemRead   = 1'b1;
          ALUSrcB   = 2'b01;
          IRWrite   = mem_ready;
          PCWrite   = mem_ready;
          nextState = mem_ready ? S_DECODE : S_FETCH;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          case (opcode)
            OP_RTYPE:         nextState = S_REXEC;
            OP_LW, OP_SW:     nextState = S_MEMADDR;
            OP_ADDIU, OP_SLTI: nextState = S_IEXEC;
            OP_BEQ:           nextState = S_BRANCH;
            OP_J:             nextState = S_JUMP;
            default:          nextState = S_ILLEGAL;
          endcase
        end
        S_MEMADDR: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          nextState = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          MemRead   = 1'b1;
          IorD      = 1'b1;
          nextState = mem_ready ? S_MEMWB : S_MEMREAD;
        end
        S_MEMWB: begin
          MemtoReg   = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEMWRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
          nextState  = mem_ready ? S_FETCH : S_MEMWRITE;
        end
        S_REXEC: begin
          ALUSrcA   = 1'b1;
          ALUOp     = 2'b10;
          nextState = S_RWB;
        end
        S_RWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_IEXEC: begin
          ALUSrcA   = 1'b1;
          ALUSrcB   = 2'b10;
          ALUOp     = 2'b11;
          nextState = S_IWB;
        end
        S_IWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ILLEGAL: begin
          illegal_op = 1'b1;
          instr_done = 1'b1;
        end
        default: nextState = S_FETCH;
      endcase
    end
  end

  assign state = curState;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized scoreboard bench for controle_multiciclo: instructions are expanded
// into expected per-cycle records that a negedge monitor compares.
module tb_controle_multiciclo;

  localparam int LIMIT = 15;

  logic       clock;
  logic       reset_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic       instr_done, illegal_op, mem_timeout;

  logic [22:0] expQ[$];
  logic [22:0] dutVec;
  int          checks = 0;
  int          errors = 0;
  int          cycleNo = 0;
  bit          monEnable = 0;

  controle_multiciclo #(.WAIT_LIMIT(LIMIT), .WAIT_W(4)) dut (
    .clock(clock), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .state(state), .instr_done(instr_done), .illegal_op(illegal_op),
    .mem_timeout(mem_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign dutVec = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                   MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                   PCSource, state, instr_done, illegal_op, mem_timeout};

  // Control word the datapath should see in a given state of the sequence.
  function automatic logic [22:0] expOut(int st, bit mr, bit to);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill;
    logic [1:0] asb, aop, pcs;
    {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, done, ill} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (!to) begin
      case (st)
        1:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
        2:  asb = 2'b11;
        3:  begin asa = 1; asb = 2'b10; end
        4:  begin mrd = 1; iord = 1; end
        5:  begin m2r = 1; rw = 1; done = 1; end
        6:  begin mwr = 1; iord = 1; done = mr; end
        7:  begin asa = 1; aop = 2'b10; end
        8:  begin rdst = 1; rw = 1; done = 1; end
        9:  begin asa = 1; asb = 2'b10; aop = 2'b11; end
        10: begin rw = 1; done = 1; end
        11: begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; done = 1; end
        12: begin pcw = 1; pcs = 2'b10; done = 1; end
        13: begin ill = 1; done = 1; end
        default: ;
      endcase
    end
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa, asb, aop, pcs,
            4'(st), done, ill, to};
  endfunction

  task automatic checkOutput(string name, logic [22:0] got, logic [22:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s cycle %0d: got %h want %h", name, cycleNo, got, want);
    end
  endtask

  // Drive one cycle, record what the DUT must show, then move to the next cycle.
  task automatic applyStimulus(int st, bit mr, bit to);
    mem_ready = mr;
    expQ.push_back(expOut(st, mr, to));
    @(posedge clock);
    #1;
  endtask

  task automatic memPhase(int st, int w, output bit aborted);
    int stalls = (w > LIMIT) ? LIMIT : w;
    for (int i = 0; i < stalls; i++) applyStimulus(st, 1'b0, 1'b0);
    if (w > LIMIT) begin
      applyStimulus(st, 1'b0, 1'b1);
      aborted = 1'b1;
    end else begin
      applyStimulus(st, 1'b1, 1'b0);
      aborted = 1'b0;
    end
  endtask

  task automatic runInstr(logic [5:0] op, int wFetch, int wMem);
    bit ab;
    opcode = op;
    memPhase(1, wFetch, ab);
    if (ab) return;
    applyStimulus(2, 1'($urandom_range(0, 1)), 1'b0);
    case (op)
      6'h00: begin applyStimulus(7, 1'b1, 1'b0); applyStimulus(8, 1'b0, 1'b0); end
      6'h23: begin
        applyStimulus(3, 1'b0, 1'b0);
        memPhase(4, wMem, ab);
        if (!ab) applyStimulus(5, 1'($urandom_range(0, 1)), 1'b0);
      end
      6'h2B: begin applyStimulus(3, 1'b1, 1'b0); memPhase(6, wMem, ab); end
      6'h09, 6'h0A: begin applyStimulus(9, 1'b0, 1'b0); applyStimulus(10, 1'b1, 1'b0); end
      6'h04: applyStimulus(11, 1'($urandom_range(0, 1)), 1'b0);
      6'h02: applyStimulus(12, 1'($urandom_range(0, 1)), 1'b0);
      default: applyStimulus(13, 1'($urandom_range(0, 1)), 1'b0);
    endcase
  endtask

  function automatic int pickWait();
    int r = $urandom_range(0, 19);
    if (r < 12) return 0;
    if (r < 17) return $urandom_range(1, 4);
    if (r == 17) return LIMIT;
    return LIMIT + 1;
  endfunction

  function automatic logic [5:0] pickOp();
    logic [5:0] legal[7] = '{6'h00, 6'h23, 6'h2B, 6'h09, 6'h0A, 6'h04, 6'h02};
    int r = $urandom_range(0, 9);
    if (r < 7) return legal[r];
    return 6'($urandom_range(0, 63));
  endfunction

  initial begin
    forever begin
      @(negedge clock);
      cycleNo++;
      if (monEnable) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL scoreboard cycle %0d: got empty queue want entry", cycleNo);
        end else begin
          checkOutput("sequence", dutVec, expQ.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    repeat (3) begin
      @(negedge clock);
      checkOutput("reset", dutVec, expOut(0, 1'b0, 1'b0));
    end
    @(posedge clock);
    #1;
    reset_n   = 1'b1;
    monEnable = 1'b1;
    applyStimulus(0, 1'b1, 1'b0);

    runInstr(6'h00, 0, 0);
    runInstr(6'h23, 0, 3);
    runInstr(6'h04, 0, 0);
    runInstr(6'h02, 0, 0);
    runInstr(6'h3F, 0, 0);
    runInstr(6'h2B, 0, LIMIT);
    runInstr(6'h2B, 0, LIMIT + 1);
    runInstr(6'h09, 2, 0);
    runInstr(6'h0A, LIMIT + 1, 0);
    runInstr(6'h23, 1, LIMIT + 1);
    runInstr(6'h0A, 0, 0);
    for (int n = 0; n < 150; n++) runInstr(pickOp(), pickWait(), pickWait());
    monEnable = 1'b0;

    // Reset asserted while a store is waiting on memory.
    opcode = 6'h2B;
    mem_ready = 1'b1;
    repeat (3) begin @(posedge clock); #1; end
    mem_ready = 1'b0;
    @(posedge clock);
    #1;
    @(negedge clock);
    checkOutput("sw_wait", dutVec, expOut(6, 1'b0, 1'b0));
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("async_reset", dutVec, expOut(0, 1'b0, 1'b0));
    @(posedge clock);
    #1;
    checkOutput("held_reset", dutVec, expOut(0, 1'b0, 1'b0));
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    @(posedge clock);
    #1;
    checkOutput("post_reset_fetch", dutVec, expOut(1, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
Multicycle control FSM for the MIPS core. It sequences a shared-memory, single-ALU datapath through fetch/decode/execute/memory/writeback over several cycles, and issues Moore-style control strobes per state. It supports the same opcode set as the single-cycle control unit. A memory handshake (mem_ready) with a bounded wait counter stalls the sequence while memory is busy.

Parameters:
WAIT_LIMIT, 15, max cycles spent waiting for mem_ready in one memory state before abort; 0 disables the timeout.
WAIT_W, 4, width of the wait counter; must satisfy 2^WAIT_W > WAIT_LIMIT.

Ports:
clock  input  1  system clock, rising edge.
reset_n  input  1  asynchronous, active-low reset.
opcode  input  6  instr[31:26] from the IR; sampled only in DECODE and MEMADDR.
mem_ready  input  1  memory completed the current read/write this cycle.
PCWrite  output  1  unconditional PC load.
PCWriteCond  output  1  PC load qualified by ALU zero (beq).
IorD  output  1  memory address select: 0=PC, 1=ALUOut.
MemRead  output  1  memory read strobe.
MemWrite  output  1  memory write strobe.
IRWrite  output  1  instruction register load.
MemtoReg  output  1  register write data select: 1=MDR, 0=ALUOut.
RegDst  output  1  destination register select: 1=rd, 0=rt.
RegWrite  output  1  register file write enable.
ALUSrcA  output  1  ALU operand A: 0=PC, 1=rs.
ALUSrcB  output  2  ALU operand B: 00=rt, 01=4, 10=signext imm, 11=signext imm<<2.
ALUOp  output  2  00=add, 01=sub, 10=funct-decoded, 11=opcode-decoded immediate op.
PCSource  output  2  00=ALU result, 01=ALUOut, 10=jump target.
state  output  4  current state encoding, for debug.
instr_done  output  1  one-cycle pulse in the final cycle of each instruction.
illegal_op  output  1  one-cycle pulse on an unsupported opcode.
mem_timeout  output  1  one-cycle pulse on a wait-limit abort.

Behaviour:
- States and encodings: RESET=0, FETCH=1, DECODE=2, MEMADDR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, REXEC=7, RWB=8, IEXEC=9, IWB=10, BRANCH=11, JUMP=12, ILLEGAL=13. Encodings 14-15 go to FETCH.
- Reset (async, reset_n=0): state=RESET and wait counter=0. All outputs are 0 while in RESET. RESET->FETCH unconditionally on the next edge. Reset mid-instruction aborts immediately; no strobe survives the reset.
- Outputs not listed for a state are 0.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (Mealy-qualified). Moves to DECODE when mem_ready=1; otherwise stays.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 -> REXEC
  - 100011 or 101011 -> MEMADDR
  - 001001 or 001010 -> IEXEC
  - 000100 -> BRANCH
  - 000010 -> JUMP
  - any other opcode -> ILLEGAL
- MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMREAD if opcode=100011, else MEMWRITE.
- MEMREAD: MemRead=1, IorD=1. Moves to MEMWB on mem_ready.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite=1, instr_done=1. Next FETCH.
- MEMWRITE: MemWrite=1, IorD=1; instr_done=mem_ready. Moves to FETCH on mem_ready.
- REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Next RWB.
- RWB: RegDst=1, MemtoReg=0, RegWrite=1, instr_done=1. Next FETCH.
- IEXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=11. Next IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite=1, instr_done=1. Next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1. Next FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1. Next FETCH.
- ILLEGAL: illegal_op=1, instr_done=1. Next FETCH; the PC has already advanced by 4, so the instruction is skipped.
- Latency with mem_ready tied to 1:
  - R-type: 4 cycles
  - addiu/slti: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/j: 3 cycles
  - illegal: 3 cycles
  - Each memory state adds one cycle per cycle in which mem_ready=0.
- Wait counter (memory states FETCH, MEMREAD, MEMWRITE):
  - Clears on entry to each memory state.
  - Increments each cycle mem_ready=0.
  - If WAIT_LIMIT!=0 and the counter equals WAIT_LIMIT with mem_ready still 0: assert mem_timeout for that cycle, drop the strobes of that state, and next state is FETCH. The counter saturates and never wraps.
  - mem_ready=1 in the same cycle as the limit counts as success; no timeout.
- instr_done and illegal_op are never asserted simultaneously with mem_timeout.

Test Plan:
- reset_n=0 for 3 cycles, then released, mem_ready=1 -> all outputs 0 in RESET, state=1 on the next edge, FETCH shows MemRead=1, IRWrite=1, PCWrite=1.
- opcode=000000, mem_ready=1 -> states 1,2,7,8. In RWB: RegDst=1, RegWrite=1, instr_done=1. Back to state 1 on cycle 5.
- opcode=100011, mem_ready held 0 for 3 cycles in MEMREAD -> state stays 4 for 4 cycles. MEMWB follows with MemtoReg=1, RegWrite=1. Total 8 cycles.
- opcode=000100, then 000010 -> BRANCH asserts PCWriteCond=1, PCSource=01, ALUOp=01. JUMP asserts PCWrite=1, PCSource=10. Each takes 3 cycles.
- opcode=111111 -> state 13, illegal_op pulse of exactly 1 cycle, return to FETCH, no RegWrite/MemWrite asserted.
- WAIT_LIMIT=15, opcode=101011, mem_ready=0 forever in MEMWRITE -> mem_timeout pulse on the 16th MEMWRITE cycle, state=1 next. Repeat with reset_n=0 asserted in MEMWRITE -> immediate state=0 and MemWrite=0.
